// File: rtl/lf_spi_cfg_regs_if.sv
// SPI pin bundle between the ARM (master) and the LF configuration receiver (slave).
interface lf_spi_cfg_regs_if;
  logic spck;
  logic mosi;
  logic ncs;
  logic miso;

  modport master (output spck, output mosi, output ncs, input miso);
  modport slave  (input spck, input mosi, input ncs, output miso);
endinterface

// File: rtl/lf_spi_cfg_regs.sv
// LF SPI configuration receiver: oversamples the SPI pins in pck0 and decodes 16-bit frames into registers.
// Optional readback over miso is built only when FPGA_SPI_READBACK_EN is defined.
module lf_spi_cfg_regs #(
  parameter int NUM_USER          = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int FRAME_BITS        = 16,
  parameter int BLANK_CYCLES      = 8,
  parameter int DIV_RESET         = 95,
  parameter int ED_DEFAULT_THRESH = 127
) (
  input  logic                  pck0,
  input  logic                  rst,
  lf_spi_cfg_regs_if.slave      spi,
  output logic [7:0]            conf_word,
  output logic [7:0]            divisor,
  output logic [8*NUM_USER-1:0] user_bytes,
  output logic [2:0]            major_mode,
  output logic                  mode_valid,
  output logic                  cmd_strobe,
  output logic                  frame_err
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam int BW = $clog2(BLANK_CYCLES + 1);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT, ERROR} state_t;

  logic [SYNC_STAGES-1:0] spck_sync_q, mosi_sync_q, ncs_sync_q;
  logic                   spck_prev_q;
  logic                   spck_s, mosi_s, ncs_s, spck_rise;

  state_t                 state_q, state_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0]  sr_q, sr_d;

  logic [7:0]             conf_q, div_q;
  logic [7:0]             user_q [NUM_USER];
  logic [BW-1:0]          blank_q;
  logic [2:0]             major_q;
  logic                   valid_q, strobe_q, err_q;

  logic [3:0]             op;
  logic [7:0]             data;
  logic                   commit, wr_conf, wr_div, mode_change, ed_load;
  logic [NUM_USER-1:0]    wr_user;
  logic                   sr_unused;

  always_ff @(posedge pck0) begin
    if (rst) begin
      spck_sync_q <= '0;
      mosi_sync_q <= '0;
      ncs_sync_q  <= '0;
      spck_prev_q <= 1'b0;
    end else begin
      spck_sync_q <= {spck_sync_q[SYNC_STAGES-2:0], spi.spck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
      spck_prev_q <= spck_s;
    end
  end

  assign spck_s    = spck_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign spck_rise = spck_s & ~spck_prev_q;

  always_ff @(posedge pck0) begin
    if (rst) begin
      state_q  <= WAIT_IDLE;
      bitcnt_q <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
    end
  end

  // SHIFT is only entered with ncs low, so ncs high there is the frame's closing edge.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    case (state_q)
      WAIT_IDLE: if (ncs_s) state_d = IDLE;
      IDLE: begin
        if (!ncs_s) begin
          state_d  = SHIFT;
          bitcnt_d = '0;
        end
      end
      SHIFT: begin
        if (ncs_s) begin
          state_d = (bitcnt_q == CW'(FRAME_BITS)) ? COMMIT : ERROR;
        end else if (spck_rise) begin
          sr_d = {sr_q[FRAME_BITS-2:0], mosi_s};
          if (bitcnt_q != CW'(FRAME_BITS + 1)) bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      COMMIT:  state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign op          = sr_q[FRAME_BITS-1 -: 4];
  assign data        = sr_q[7:0];
  assign commit      = (state_q == COMMIT);
  assign wr_conf     = commit && (op == 4'h1);
  assign wr_div      = commit && (op == 4'h2);
  assign mode_change = wr_conf && (data[7:5] != conf_q[7:5]);
  assign ed_load     = wr_conf && (data == 8'h01);
  assign sr_unused   = ^sr_q[11:8];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_USER; gi++) begin : g_user
      assign wr_user[gi]           = commit && (op == 4'(3 + gi));
      assign user_bytes[8*gi +: 8] = user_q[gi];
    end
  endgenerate

  always_ff @(posedge pck0) begin
    if (rst) begin
      conf_q   <= 8'hE0;
      div_q    <= 8'(DIV_RESET);
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      for (int k = 0; k < NUM_USER; k++) user_q[k] <= 8'h00;
    end else begin
      strobe_q <= wr_conf | wr_div | (|wr_user);
      err_q    <= (state_q == ERROR);
      if (wr_conf) conf_q <= data;
      if (wr_div)  div_q  <= data;
      for (int k = 0; k < NUM_USER; k++) begin
        if (wr_user[k]) user_q[k] <= data;
      end
      if (ed_load) user_q[0] <= 8'(ED_DEFAULT_THRESH);
    end
  end

  // A fresh mode change always reloads; otherwise the count runs down and releases the latest mode.
  always_ff @(posedge pck0) begin
    if (rst) begin
      blank_q <= '0;
      major_q <= 3'b111;
      valid_q <= 1'b1;
    end else if (mode_change) begin
      blank_q <= BW'(BLANK_CYCLES);
      major_q <= 3'b111;
      valid_q <= 1'b0;
    end else if (blank_q != '0) begin
      blank_q <= blank_q - 1'b1;
      if (blank_q == BW'(1)) begin
        major_q <= conf_q[7:5];
        valid_q <= 1'b1;
      end
    end
  end

  assign conf_word  = conf_q;
  assign divisor    = div_q;
  assign major_mode = major_q;
  assign mode_valid = valid_q;
  assign cmd_strobe = strobe_q;
  assign frame_err  = err_q;

`ifdef FPGA_SPI_READBACK_EN
  logic        rb_arm_q;
  logic [3:0]  rb_addr_q;
  logic [15:0] tx_q;
  logic [7:0]  rb_data;
  logic        spck_fall;

  assign spck_fall = ~spck_s & spck_prev_q;

  always_comb begin
    rb_data = 8'h00;
    if (rb_addr_q == 4'd0) rb_data = conf_q;
    if (rb_addr_q == 4'd1) rb_data = div_q;
    for (int k = 0; k < NUM_USER; k++) begin
      if (rb_addr_q == 4'(k + 2)) rb_data = user_q[k];
    end
  end

  // The armed word is captured as the next frame opens so bit 15 is on miso before the first spck rise.
  always_ff @(posedge pck0) begin
    if (rst) begin
      rb_arm_q  <= 1'b0;
      rb_addr_q <= 4'h0;
      tx_q      <= '0;
    end else begin
      if (commit && op == 4'hF) begin
        rb_arm_q  <= 1'b1;
        rb_addr_q <= sr_q[3:0];
      end else if (state_q == ERROR) begin
        rb_arm_q <= 1'b0;
      end
      if (state_q == IDLE && !ncs_s) begin
        tx_q     <= rb_arm_q ? {4'hF, rb_addr_q, rb_data} : 16'h0000;
        rb_arm_q <= 1'b0;
      end else if (ncs_s) begin
        tx_q <= '0;
      end else if (state_q == SHIFT && spck_fall) begin
        tx_q <= {tx_q[14:0], 1'b0};
      end
    end
  end

  assign spi.miso = ~ncs_s & tx_q[15];
`else
  assign spi.miso = 1'b0;
`endif

endmodule

// File: tb/tb_lf_spi_cfg_regs.sv
// Directed bench for lf_spi_cfg_regs; readback steps run only when FPGA_SPI_READBACK_EN is defined.
module tb_lf_spi_cfg_regs;
  logic        pck0 = 1'b0;
  logic        rst;
  logic [7:0]  conf_word, divisor;
  logic [31:0] user_bytes;
  logic [2:0]  major_mode;
  logic        mode_valid, cmd_strobe, frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int err_cnt    = 0;

  lf_spi_cfg_regs_if spi ();

  lf_spi_cfg_regs dut (
    .pck0       (pck0),
    .rst        (rst),
    .spi        (spi),
    .conf_word  (conf_word),
    .divisor    (divisor),
    .user_bytes (user_bytes),
    .major_mode (major_mode),
    .mode_valid (mode_valid),
    .cmd_strobe (cmd_strobe),
    .frame_err  (frame_err)
  );

  always #5 pck0 = ~pck0;

  always @(negedge pck0) begin
    if (cmd_strobe === 1'b1) strobe_cnt++;
    if (frame_err === 1'b1)  err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pck0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic rx_bit);
    spi.mosi = b;
    tick(4);
    rx_bit = spi.miso;
    spi.spck = 1'b1;
    tick(4);
    spi.spck = 1'b0;
  endtask

  // Leaves ncs high on return; caller decides how long to wait.
  task automatic send_frame(input logic [31:0] val, input int nbits, output logic [31:0] rx);
    logic b;
    rx = '0;
    spi.ncs = 1'b0;
    tick(8);
    for (int i = nbits - 1; i >= 0; i--) begin
      send_bit(val[i], b);
      rx = {rx[30:0], b};
    end
    tick(4);
    spi.ncs  = 1'b1;
    spi.mosi = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int k;
    for (k = 0; k < 12; k++) begin
      tick(1);
      if (cmd_strobe === 1'b1) break;
    end
    chk(tag, {31'd0, cmd_strobe}, 32'd1);
  endtask

  initial begin
    logic [31:0] rx;
    logic        b;
    int          s0, e0, blank;

    rst = 1'b1; spi.spck = 1'b0; spi.mosi = 1'b0; spi.ncs = 1'b1;
    tick(5);
    chk("rst_conf",   {24'd0, conf_word}, 32'hE0);
    chk("rst_div",    {24'd0, divisor}, 32'd95);
    chk("rst_user",   user_bytes, 32'h0);
    chk("rst_major",  {29'd0, major_mode}, 32'h7);
    chk("rst_valid",  {31'd0, mode_valid}, 32'd1);
    chk("rst_strobe", {31'd0, cmd_strobe}, 32'd0);
    chk("rst_err",    {31'd0, frame_err}, 32'd0);
    chk("rst_miso",   {31'd0, spi.miso}, 32'd0);
    rst = 1'b0;
    tick(6);

    // Mode change 111 -> 001 blanks for BLANK_CYCLES cycles
    s0 = strobe_cnt;
    send_frame(32'h1020, 16, rx);
    wait_strobe("blank_strobe");
    chk("blank_conf",  {24'd0, conf_word}, 32'h20);
    chk("blank_major", {29'd0, major_mode}, 32'h7);
    chk("blank_valid", {31'd0, mode_valid}, 32'd0);
    blank = 1;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (mode_valid === 1'b1) break;
      blank++;
    end
    chk("blank_len",   blank, 32'd8);
    chk("blank_after", {29'd0, major_mode}, 32'h1);
    tick(4);
    chk("blank_nstrobe", strobe_cnt - s0, 32'd1);

    // Energy-detect default load alongside conf_word = 01
    send_frame(32'h3005, 16, rx);
    tick(10);
    chk("user0_05", {24'd0, user_bytes[7:0]}, 32'h05);
    send_frame(32'h1001, 16, rx);
    wait_strobe("ed_strobe");
    chk("ed_conf",  {24'd0, conf_word}, 32'h01);
    chk("ed_user0", {24'd0, user_bytes[7:0]}, 32'h7F);
    tick(14);

    // Latency: visible SYNC_STAGES+2 cycles after ncs rises
    send_frame(32'h2040, 16, rx);
    tick(3);
    chk("lat_before", {24'd0, divisor}, 32'd95);
    tick(1);
    chk("lat_strobe", {31'd0, cmd_strobe}, 32'd1);
    chk("lat_div",    {24'd0, divisor}, 32'h40);
    tick(6);
    send_frame(32'h4011, 16, rx);
    tick(10);
    send_frame(32'h6022, 16, rx);
    tick(10);
    chk("user_all", user_bytes, 32'h2200117F);

    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(32'h9033, 16, rx);
    tick(10);
    chk("op9_strobe", strobe_cnt - s0, 32'd0);
    chk("op9_err",    err_cnt - e0, 32'd0);
    chk("op9_user",   user_bytes, 32'h2200117F);
    chk("op9_conf",   {24'd0, conf_word}, 32'h01);

    // Short, long and empty frames
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(32'h20BB, 15, rx);
    tick(10);
    chk("short_err", err_cnt - e0, 32'd1);
    chk("short_div", {24'd0, divisor}, 32'h40);
    send_frame(32'h120BB, 17, rx);
    tick(10);
    chk("long_err", err_cnt - e0, 32'd2);
    chk("long_div", {24'd0, divisor}, 32'h40);
    send_frame(32'h0, 0, rx);
    tick(10);
    chk("empty_err",  err_cnt - e0, 32'd3);
    chk("bad_strobe", strobe_cnt - s0, 32'd0);
    chk("bad_user",   user_bytes, 32'h2200117F);
    send_frame(32'h20AA, 16, rx);
    tick(10);
    chk("div_AA", {24'd0, divisor}, 32'hAA);

`ifdef FPGA_SPI_READBACK_EN
    chk("rb_idle_miso", {31'd0, spi.miso}, 32'd0);
    send_frame(32'hF001, 16, rx);
    tick(10);
    send_frame(32'h0000, 16, rx);
    tick(10);
    chk("rb_word", {16'd0, rx[15:0]}, 32'hF1AA);
    chk("rb_miso_end", {31'd0, spi.miso}, 32'd0);
`endif

    // Reset mid-frame: the tail of the frame must be discarded silently
    spi.ncs = 1'b0;
    tick(8);
    for (int i = 7; i >= 0; i--) send_bit(1'((32'h20 >> i) & 1), b);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    s0 = strobe_cnt; e0 = err_cnt;
    for (int i = 7; i >= 0; i--) send_bit(1'((32'hCC >> i) & 1), b);
    tick(4);
    spi.ncs = 1'b1;
    tick(10);
    chk("mid_div",    {24'd0, divisor}, 32'd95);
    chk("mid_conf",   {24'd0, conf_word}, 32'hE0);
    chk("mid_strobe", strobe_cnt - s0, 32'd0);
    chk("mid_err",    err_cnt - e0, 32'd0);
    send_frame(32'h2055, 16, rx);
    tick(10);
    chk("post_div",    {24'd0, divisor}, 32'h55);
    chk("post_strobe", strobe_cnt - s0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
